// File: rtl/alu_seq_pkg.sv
// Shared opcodes and error classification for the ALU command sequencer.
// The sequencer and its FIFOs import this package.
package alu_seq_pkg;

  localparam int DW_DEF  = 4;
  localparam int OPW_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b111;

  // Divide by zero or any 11x opcode yields a flagged, zeroed response
  function automatic logic is_err(
    input logic [2:0] op,
    input logic       b_zero
  );
    return ((op == OP_DIV) && b_zero) || (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Count-based synchronous FIFO; push while full is accepted only
// when a pop happens in the same cycle.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds a registered ALU from a command queue, tracks its latency and
// returns flagged results in order, never over-committing response slots.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int DW        = DW_DEF,
  parameter int OPW       = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  input  logic [OPW-1:0]  cmd_op,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [2*DW-1:0] alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_result,
  output logic            rsp_err,
  output logic            busy
);

  localparam int CW  = 2*DW + OPW;
  localparam int RW  = 2*DW + 1;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [RAW+1:0] RSP_LIM = RSP_DEPTH[RAW+1:0];
  localparam logic [OPW-1:0] NOP = OPW'(OP_NOP);

  logic [CW-1:0]    cmd_wdata;
  logic [CW-1:0]    cmd_rdata;
  logic             cmd_push;
  logic             cmd_full;
  logic             cmd_empty;
  logic [CAW:0]     cmd_count;
  logic [DW-1:0]    head_a;
  logic [DW-1:0]    head_b;
  logic [OPW-1:0]   head_op;

  logic [RW-1:0]    rsp_wdata;
  logic [RW-1:0]    rsp_rdata;
  logic             rsp_pop;
  logic             rsp_full;
  logic             rsp_empty;
  logic [RAW:0]     rsp_count;

  logic             s1_v;
  logic             s1_err;
  logic             s2_v;
  logic             s2_err;
  logic [RAW+1:0]   used;
  logic             credit_ok;
  logic             issue;
  logic             issue_err;

  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_wdata = {cmd_a, cmd_b, cmd_op};
  assign {head_a, head_b, head_op} = cmd_rdata;

  alu_seq_fifo #(
    .WIDTH (CW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .wdata (cmd_wdata),
    .pop   (issue),
    .rdata (cmd_rdata),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  // Slots already spoken for: stored results plus both pipeline stages
  assign used = (RAW+2)'(rsp_count)
              + (RAW+2)'(s1_v)
              + (RAW+2)'(s2_v);
  assign credit_ok = (used < RSP_LIM) && !rsp_full;
  assign issue     = !cmd_empty && credit_ok;
  assign issue_err = is_err(3'(head_op), head_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= NOP;
      s1_v   <= 1'b0;
      s1_err <= 1'b0;
      s2_v   <= 1'b0;
      s2_err <= 1'b0;
    end else begin
      s1_v   <= issue;
      s2_v   <= s1_v;
      s2_err <= s1_err;
      if (issue) begin
        alu_a  <= head_a;
        alu_b  <= head_b;
        alu_op <= head_op;
        s1_err <= issue_err;
      end else begin
        alu_op <= NOP;
        s1_err <= 1'b0;
      end
    end
  end

  assign rsp_wdata = {s2_err ? '0 : alu_result, s2_err};
  assign rsp_pop   = rsp_valid && rsp_ready;

  alu_seq_fifo #(
    .WIDTH (RW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_v),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_rdata),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // Storage is not reset, so present zeros whenever nothing is valid
  assign rsp_valid  = !rsp_empty;
  assign rsp_result = rsp_valid ? rsp_rdata[RW-1:1] : '0;
  assign rsp_err    = rsp_valid && rsp_rdata[0];

  assign busy = (cmd_count != '0) || s1_v || s2_v || rsp_valid;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer driving a registered 4-bit ALU.
// Directed cases, backpressure, mid-run reset and a long random run.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_err;
  logic       busy;

  logic       rnd_mode = 1'b0;
  logic       rdy_fixed = 1'b1;
  logic       rnd_bit = 1'b1;

  logic [8:0] exp_q[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         npass = 0;
  int         ntotal = 0;
  int         issue_cnt = 0;

  assign rsp_ready = rnd_mode ? rnd_bit : rdy_fixed;

  alu_cmd_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Registered ALU; junk on div-by-zero/illegal so the zero force is visible
  always @(posedge clk or posedge rst) begin
    if (rst) alu_result <= 8'h00;
    else begin
      case (alu_op)
        3'd0: alu_result <= 8'(alu_a) + 8'(alu_b);
        3'd1: alu_result <= 8'(alu_a) - 8'(alu_b);
        3'd2: alu_result <= 8'(alu_a) * 8'(alu_b);
        3'd3: alu_result <= (alu_b == 0) ? 8'hFF : 8'(alu_a / alu_b);
        3'd4: alu_result <= {4'h0, alu_a & alu_b};
        3'd5: alu_result <= {4'h0, alu_a | alu_b};
        3'd6: alu_result <= 8'hAA;
        default: alu_result <= 8'h00;
      endcase
    end
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [8:0] ref_rsp(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] op
  );
    logic [7:0] r;
    logic       e;
    e = ((op == 3'd3) && (b == 4'd0)) || (op[2:1] == 2'b11);
    r = 8'h00;
    case (op)
      3'd0: r = {4'h0, a} + {4'h0, b};
      3'd1: r = {4'h0, a} - {4'h0, b};
      3'd2: r = {4'h0, a} * {4'h0, b};
      3'd3: if (b != 0) r = {4'h0, a / b};
      3'd4: r = {4'h0, a & b};
      3'd5: r = {4'h0, a | b};
      default: r = 8'h00;
    endcase
    return e ? 9'h001 : {r, 1'b0};
  endfunction

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    ntotal++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          ntotal++;
          $display("FAIL unexpected_rsp: got %h/%b required none",
                   rsp_result, rsp_err);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rsp", 32'({rsp_result, rsp_err}), 32'(e));
        end
      end
    end
  endtask

  task automatic issue_counter();
    forever begin
      @(negedge clk);
      if (!rst && alu_op != 3'b111) issue_cnt++;
    end
  endtask

  // Called and returns at posedge+1; pushes the expectation once accepted
  task automatic send(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] op,
    input logic [8:0] req
  );
    bit done;
    done = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back(req);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      ntotal++;
      $display("FAIL send_timeout: got no accept required accept");
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n < limit), 32'd1);
  endtask

  initial begin
    logic [3:0] va;
    logic [3:0] vb;
    logic [2:0] vo;
    logic [3:0] vbits;
    int         base;
    int         ib;

    fork
      monitor_loop();
      issue_counter();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd7);
    check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single command latency
    send(4'd3, 4'd5, 3'd0, {8'h08, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vbits[i] = rsp_valid;
    end
    @(posedge clk);
    #1;
    check("latency", 32'(vbits), 32'b1000);
    drain("drain1", 50);

    // Back-to-back results on consecutive cycles
    base = pop_cyc.size();
    send(4'd2, 4'd3, 3'd1, {8'hFF, 1'b0});
    send(4'd15, 4'd15, 3'd2, {8'hE1, 1'b0});
    send(4'd9, 4'd2, 3'd3, {8'h04, 1'b0});
    drain("drain2", 50);
    check("b2b_count", 32'(pop_cyc.size() - base), 32'd3);
    if (pop_cyc.size() - base == 3) begin
      check("b2b_gap0", 32'(pop_cyc[base+1] - pop_cyc[base]), 32'd1);
      check("b2b_gap1", 32'(pop_cyc[base+2] - pop_cyc[base+1]), 32'd1);
    end

    // Error forcing then a clean result
    send(4'd9, 4'd0, 3'd3, {8'h00, 1'b1});
    send(4'd4, 4'd7, 3'd6, {8'h00, 1'b1});
    send(4'd1, 4'd1, 3'd0, {8'h02, 1'b0});
    drain("drain3", 50);

    // Backpressure: credits cap issue at RSP_DEPTH
    rdy_fixed = 1'b0;
    base = pop_cyc.size();
    ib = issue_cnt;
    for (int i = 0; i < 8; i++) begin
      va = 4'(i);
      vb = 4'(i + 1);
      vo = 3'(i % 6);
      send(va, vb, vo, ref_rsp(va, vb, vo));
    end
    repeat (6) @(posedge clk);
    #1;
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_issued", 32'(issue_cnt - ib), 32'd4);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    rdy_fixed = 1'b1;
    for (int i = 8; i < 10; i++) begin
      va = 4'(i);
      vb = 4'(i + 1);
      vo = 3'(i % 6);
      send(va, vb, vo, ref_rsp(va, vb, vo));
    end
    drain("drain4", 100);
    check("bp_returned", 32'(pop_cyc.size() - base), 32'd10);

    // Reset with work queued and in flight
    rdy_fixed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      va = 4'(i + 3);
      vb = 4'(i + 2);
      vo = 3'(i % 6);
      send(va, vb, vo, ref_rsp(va, vb, vo));
    end
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_alu_op", 32'(alu_op), 32'd7);
    check("mid_rst_rsp", 32'({rsp_result, rsp_err}), 32'd0);
    exp_q.delete();
    rdy_fixed = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = pop_cyc.size();
    repeat (10) @(posedge clk);
    #1;
    check("no_stale", 32'(pop_cyc.size() - base), 32'd0);
    send(4'd1, 4'd1, 3'd0, {8'h02, 1'b0});
    drain("drain5", 50);

    // Random traffic on both sides
    rnd_mode = 1'b1;
    base = pop_cyc.size();
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      va = 4'($urandom);
      vb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      vo = 3'($urandom);
      send(va, vb, vo, ref_rsp(va, vb, vo));
    end
    rnd_mode = 1'b0;
    drain("drain6", 200);
    check("rnd_returned", 32'(pop_cyc.size() - base), 32'd10000);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
